// File: rtl/lobster_cache_pkg.sv
// Shared types for the lobster_cache client: op encodings, sequencer states
// and the FIND-miss marker value.
package lobster_cache_pkg;

  typedef enum logic [1:0] {
    OP_READ         = 2'd0,
    OP_WRITE        = 2'd1,
    OP_FIND         = 2'd2,
    OP_WRITE_VERIFY = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    VRD,
    WAIT,
    RSP
  } state_e;

  // FIND-miss marker at the default 32-bit data width: MSB set, rest zero.
  localparam logic [31:0] NOT_FOUND = 32'h8000_0000;

endpackage

// File: rtl/lobster_sat_counter.sv
// Saturating event counter: counts single-cycle inc pulses and sticks at all-ones.
module lobster_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count up on inc, holding once the all-ones ceiling is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lobster_cache_client.sv
// Initiator-side sequencer for the lobster_cache responder. Takes one op at a
// time, drives the cache pins, absorbs the cache's registered read latency and
// returns a held response with hit/mismatch flags plus saturating statistics.
module lobster_cache_client
  import lobster_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  output logic                  c_we,
  output logic                  c_find,
  output logic [ADDR_WIDTH-1:0] c_addr_in,
  output logic [ADDR_WIDTH-1:0] c_addr_out,
  output logic [DATA_WIDTH-1:0] c_data_in,
  input  logic [DATA_WIDTH-1:0] c_data_out,
  output logic [CNT_WIDTH-1:0]  cnt_rd,
  output logic [CNT_WIDTH-1:0]  cnt_wr,
  output logic [CNT_WIDTH-1:0]  cnt_miss
);

  localparam logic [DATA_WIDTH-1:0] NOT_FOUND_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state;
  state_e                state_nxt;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  accept;
  logic                  rsp_done;
  logic                  inc_rd;
  logic                  inc_wr;
  logic                  inc_miss;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign accept    = req_valid && req_ready;
  assign rsp_done  = rsp_valid && rsp_ready;

  // Sequencer state register; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and cache pin drive: issue straight from req_* on accept, replay the address for the verify read.
  always_comb begin
    state_nxt  = state;
    c_we       = 1'b0;
    c_find     = 1'b0;
    c_addr_in  = '0;
    c_addr_out = '0;
    c_data_in  = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (op_e'(req_op))
            OP_READ: begin
              c_addr_out = req_addr;
              state_nxt  = WAIT;
            end
            OP_FIND: begin
              c_find    = 1'b1;
              c_data_in = req_data;
              state_nxt = WAIT;
            end
            OP_WRITE: begin
              c_we      = 1'b1;
              c_addr_in = req_addr;
              c_data_in = req_data;
              state_nxt = RSP;
            end
            OP_WRITE_VERIFY: begin
              c_we      = 1'b1;
              c_addr_in = req_addr;
              c_data_in = req_data;
              state_nxt = VRD;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      VRD: begin
        c_addr_out = addr_q;
        state_nxt  = WAIT;
      end
      WAIT: state_nxt = RSP;
      RSP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request on accept and build the response once cache data is back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      data_q   <= '0;
      rsp_data <= '0;
      rsp_hit  <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      op_q     <= op_e'(req_op);
      addr_q   <= req_addr;
      data_q   <= req_data;
      rsp_data <= req_data;
      rsp_hit  <= 1'b1;
      rsp_err  <= 1'b0;
    end else if (state == WAIT) begin
      case (op_q)
        OP_FIND: begin
          rsp_hit  <= ~c_data_out[DATA_WIDTH-1];
          rsp_data <= c_data_out[DATA_WIDTH-1] ? NOT_FOUND_W : c_data_out;
        end
        OP_WRITE_VERIFY: begin
          rsp_data <= c_data_out;
          rsp_err  <= (c_data_out != data_q);
        end
        default: rsp_data <= c_data_out;
      endcase
    end
  end

  assign inc_rd   = rsp_done && (op_q == OP_READ);
  assign inc_wr   = rsp_done && ((op_q == OP_WRITE) || (op_q == OP_WRITE_VERIFY));
  assign inc_miss = rsp_done && (op_q == OP_FIND) && !rsp_hit;

  lobster_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_rd),
    .count (cnt_rd)
  );

  lobster_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_wr),
    .count (cnt_wr)
  );

  lobster_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_miss (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_miss),
    .count (cnt_miss)
  );

endmodule

// File: tb/tb_lobster_cache_client.sv
// Bench for lobster_cache_client: an ideal behavioural cache stub answers the
// pins with one cycle of registered latency, and a key/value reference model
// predicts every response, latency and statistics counter.
module tb_lobster_cache_client;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [1:0] OP_RD = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_FD = 2'd2;
  localparam logic [1:0] OP_WV = 2'd3;
  localparam logic [31:0] MISS_VALUE = 32'h8000_0000;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_hit;
  logic          rsp_err;
  logic          c_we;
  logic          c_find;
  logic [AW-1:0] c_addr_in;
  logic [AW-1:0] c_addr_out;
  logic [DW-1:0] c_data_in;
  logic [DW-1:0] c_data_out;
  logic [CW-1:0] cnt_rd;
  logic [CW-1:0] cnt_wr;
  logic [CW-1:0] cnt_miss;

  int check_count;
  int pass_count;

  // reference model state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            m_rd;
  int            m_wr;
  int            m_miss;

  // cache stub state
  logic [DW-1:0] stub_mem [logic [AW-1:0]];
  logic [DW-1:0] stub_out;
  logic          force_zero;

  lobster_cache_client #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_hit    (rsp_hit),
    .rsp_err    (rsp_err),
    .c_we       (c_we),
    .c_find     (c_find),
    .c_addr_in  (c_addr_in),
    .c_addr_out (c_addr_out),
    .c_data_in  (c_data_in),
    .c_data_out (c_data_out),
    .cnt_rd     (cnt_rd),
    .cnt_wr     (cnt_wr),
    .cnt_miss   (cnt_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign c_data_out = force_zero ? '0 : stub_out;

  // Slot index a found key reports (stands in for the cache's hash).
  function automatic logic [11:0] hash_idx(input logic [31:0] k);
    return k[11:0] ^ k[23:12] ^ {4'b0, k[31:24]};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Ideal cache: read/find result registered one edge later, write after the read.
  always @(posedge clk) begin : cache_stub
    logic [DW-1:0] rd;
    logic          found;
    rd    = '0;
    found = 1'b0;
    if (c_find) begin
      rd = MISS_VALUE;
      foreach (stub_mem[k]) begin
        if (!found && stub_mem[k] == c_data_in) begin
          found = 1'b1;
          rd    = {20'b0, hash_idx(k)};
        end
      end
    end else if (stub_mem.exists(c_addr_out)) begin
      rd = stub_mem[c_addr_out];
    end
    if (c_we) stub_mem[c_addr_in] = c_data_in;
    stub_out <= rd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // we and find must never pulse together
  always @(negedge clk) begin
    if (rst_n) checkOutput("weFindExclusive", {31'b0, c_we & c_find}, 32'd0);
  end

  // Run one op end to end and compare every observable against the reference model.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input int hold,
                               input bit poke);
    logic [31:0] exp_data;
    logic        exp_hit;
    logic        exp_err;
    int          exp_lat;
    int          lat;
    int          waited;
    bit          found;
    exp_hit = 1'b1;
    exp_err = 1'b0;
    exp_data = '0;
    exp_lat  = 2;
    case (op)
      OP_RD: begin
        exp_data = ref_mem.exists(addr) ? ref_mem[addr] : 32'd0;
        exp_lat  = 2;
      end
      OP_WR: begin
        ref_mem[addr] = data;
        exp_data = data;
        exp_lat  = 1;
      end
      OP_FD: begin
        found    = 1'b0;
        exp_data = MISS_VALUE;
        foreach (ref_mem[k]) begin
          if (!found && ref_mem[k] == data) begin
            found    = 1'b1;
            exp_data = 32'(hash_idx(k));
          end
        end
        exp_hit = found;
        exp_lat = 2;
      end
      default: begin
        ref_mem[addr] = data;
        exp_data = force_zero ? 32'd0 : data;
        exp_err  = (exp_data != data);
        exp_lat  = 3;
      end
    endcase

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    waited    = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("reqReadyTimeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rspData", rsp_data, exp_data);
    checkOutput("rspHit", {31'b0, rsp_hit}, {31'b0, exp_hit});
    checkOutput("rspErr", {31'b0, rsp_err}, {31'b0, exp_err});

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (poke) begin
        req_valid = 1'b1;
        req_op    = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_data  = $urandom;
        #1;
        checkOutput("pokeNoWe", {31'b0, c_we | c_find}, 32'd0);
      end
      @(posedge clk);
      #1;
      checkOutput("holdValid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("holdData", rsp_data, exp_data);
      checkOutput("holdReqReady", {31'b0, req_ready}, 32'd0);
    end

    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (op == OP_RD) m_rd = sat_inc(m_rd);
    if (op == OP_WR || op == OP_WV) m_wr = sat_inc(m_wr);
    if (op == OP_FD && !exp_hit) m_miss = sat_inc(m_miss);
    checkOutput("postValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("postReqReady", {31'b0, req_ready}, 32'd1);
    checkOutput("cntRd", 32'(cnt_rd), 32'(m_rd));
    checkOutput("cntWr", 32'(cnt_wr), 32'(m_wr));
    checkOutput("cntMiss", 32'(cnt_miss), 32'(m_miss));
  endtask

  logic [31:0] addr_pool [8];

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    check_count = 0;
    pass_count  = 0;
    m_rd = 0;
    m_wr = 0;
    m_miss = 0;
    force_zero = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_addr   = '0;
    req_data   = '0;
    rsp_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReqReady", {31'b0, req_ready}, 32'd1);
    checkOutput("resetRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("resetRspData", rsp_data, 32'd0);
    checkOutput("resetCntRd", 32'(cnt_rd), 32'd0);
    checkOutput("resetWe", {31'b0, c_we | c_find}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // write then read back
    applyStimulus(OP_WR, 32'hFFF8_0000, 32'h1234_5678, 0, 1'b0);
    applyStimulus(OP_RD, 32'hFFF8_0000, 32'h0, 0, 1'b0);

    // find hit and miss
    applyStimulus(OP_FD, 32'h0, 32'h1234_5678, 0, 1'b0);
    applyStimulus(OP_FD, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);

    // write-verify clean and with corrupted readback
    applyStimulus(OP_WV, 32'h0000_0010, 32'hA5A5_A5A5, 0, 1'b0);
    force_zero = 1'b1;
    applyStimulus(OP_WV, 32'h0000_0010, 32'hA5A5_A5A5, 0, 1'b0);
    force_zero = 1'b0;

    // response back-pressure with a competing request
    applyStimulus(OP_RD, 32'hFFF8_0000, 32'h0, 5, 1'b1);

    // reset while waiting on read data
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_RD;
    req_addr  = 32'hFFF8_0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    m_rd = 0;
    m_wr = 0;
    m_miss = 0;
    checkOutput("midResetRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midResetReqReady", {31'b0, req_ready}, 32'd1);
    checkOutput("midResetCntWr", 32'(cnt_wr), 32'd0);
    checkOutput("midResetCntMiss", 32'(cnt_miss), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("afterResetNoRsp", {31'b0, rsp_valid}, 32'd0);
    end
    checkOutput("afterResetCntRd", 32'(cnt_rd), 32'd0);

    // drive the read counter into saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      applyStimulus(OP_RD, 32'h0000_FFFF, 32'h0, 0, 1'b0);
    end
    checkOutput("cntRdSaturated", 32'(cnt_rd), 32'(CNT_MAX));

    // randomized traffic over a small key pool
    for (int i = 0; i < 8; i++) addr_pool[i] = $urandom;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = addr_pool[$urandom_range(0, 7)];
      d  = $urandom;
      if (op == OP_FD && $urandom_range(0, 1) == 1 && ref_mem.exists(a)) d = ref_mem[a];
      applyStimulus(op, a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
